m_prog_loader: RTL
==================

M_PROG_LOADER -- requirements
Module: m_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the target memory.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written.
REQ-003 SHALL have port w_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port w_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port w_start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port w_rx_valid  input  1  byte on w_rx_data is valid.
REQ-007 SHALL have port w_rx_data  input  8  incoming byte stream.
REQ-008 SHALL have port r_rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port r_mem_we  output  1  memory write strobe, one cycle per word.
REQ-010 SHALL have port r_mem_addr  output  ADDR_W  memory word address.
REQ-011 SHALL have port r_mem_din  output  32  memory write data.
REQ-012 SHALL have port r_cpu_rst  output  1  active-high reset to the processor.
REQ-013 SHALL have ports r_busy, r_done, r_err  output  1 each  status flags.

Function
REQ-014 A byte is accepted only on an edge where w_rx_valid and r_rx_ready are both 1.
REQ-015 States: IDLE, HDR_HI, HDR_LO, DATA, CKSUM (macro only), ERR; r_rx_ready is 1 exactly in HDR_HI, HDR_LO, DATA and CKSUM.
REQ-016 IDLE + w_start -> HDR_HI; clear r_done and r_err, assert r_busy and r_cpu_rst on the same edge.
REQ-017 w_start outside IDLE and ERR is ignored; w_start in ERR behaves as in IDLE.
REQ-018 Header is a 16-bit big-endian word count N (HDR_HI then HDR_LO).
REQ-019 N==0 or N>2**ADDR_W -> ERR on the HDR_LO acceptance edge; otherwise -> DATA.
REQ-020 DATA: each word is 4 bytes, MSB first; the 4th accepted byte causes r_mem_we=1 on the next cycle with r_mem_din equal to the assembled word.
REQ-021 The first word is written to BASE_ADDR; r_mem_addr increments by 1 after each write, modulo 2**ADDR_W (wrap-around is legal).
REQ-022 r_rx_ready stays 1 during a write cycle; byte acceptance and a write may coincide.
REQ-023 After word N is written -> IDLE (or CKSUM with macro): r_done=1, r_busy=0, r_cpu_rst=0 one cycle after the last r_mem_we.
REQ-024 ERR: r_err=1, r_busy=0, r_cpu_rst stays 1, no further writes; state held until w_start or reset.
REQ-025 r_done and r_err are levels held until the next accepted w_start.
REQ-026 r_mem_we is never 1 outside DATA/last-write cycles; r_mem_addr and r_mem_din hold their values when r_mem_we=0.

Reset
REQ-027 On w_rst_n=0, immediately: state IDLE, r_rx_ready=0, r_mem_we=0, r_mem_addr=BASE_ADDR, r_mem_din=0, r_cpu_rst=0, r_busy=0, r_done=0, r_err=0, byte and word counters 0.
REQ-028 Reset mid-load aborts the load; words already written stay in memory; no partial word is written.

Configuration
REQ-029 With LOADER_CKSUM_EN defined, after word N the loader enters CKSUM and accepts one byte that must equal the 8-bit modulo-256 sum of all 4*N data bytes; match -> done per REQ-023, mismatch -> ERR.
REQ-030 Without LOADER_CKSUM_EN, no CKSUM state exists and the load completes after word N.

Structure
REQ-031 The shared package SHALL hold the state encoding, header byte count (2), bytes-per-word (4) and the default ADDR_W.
REQ-032 Byte-to-word packing SHALL be one sub-module, m_byte_packer (byte in, 32-bit word plus word-valid pulse out).

Verification
REQ-033 Header 0x0002, bytes 20 09 00 01 21 29 00 01 -> writes 0x20090001 @0 then 0x21290001 @1; r_done=1; r_cpu_rst falls one cycle after the second write.
REQ-034 Header 0x0000 -> r_err=1, no r_mem_we, r_cpu_rst=1; a new w_start followed by a valid load then succeeds.
REQ-035 BASE_ADDR=4094, N=3 -> writes to addresses 4094, 4095, 0.
REQ-036 w_rx_valid held at 1 continuously, N=2 -> 8 bytes accepted on 8 consecutive edges; exactly 2 write pulses.
REQ-037 w_rst_n pulsed low after 6 data bytes -> 1 write only; all outputs at reset values asynchronously.
REQ-038 With LOADER_CKSUM_EN, N=1, data 00 00 00 20 followed by checksum 0x20 -> r_done=1; the same stream with checksum 0x21 -> r_err=1.

Source files
------------

// File: rtl/m_prog_loader_pkg.sv
// Shared state encoding and framing constants for the program loader.
// LOADER_CKSUM_EN adds the trailing checksum state.
package m_prog_loader_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
`ifdef LOADER_CKSUM_EN
        CKSUM  = 3'd4,
`endif
        ERR    = 3'd5
    } ld_state_e;
endpackage

// File: rtl/m_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface m_prog_loader_if import m_prog_loader_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              w_rx_valid;
    logic [7:0]        w_rx_data;
    logic              r_rx_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_din;

    modport master (output w_rx_valid, w_rx_data,
                    input  r_rx_ready, r_mem_we, r_mem_addr, r_mem_din);
    modport slave  (input  w_rx_valid, w_rx_data,
                    output r_rx_ready, r_mem_we, r_mem_addr, r_mem_din);
endinterface

// File: rtl/m_prog_loader_byte_packer.sv
// Packs bytes MSB-first into words; r_word_vld pulses the cycle after the last byte of a word.
module m_byte_packer import m_prog_loader_pkg::*; (
    input  logic                    w_clk,
    input  logic                    w_rst_n,
    input  logic                    w_clr,
    input  logic                    w_vld,
    input  logic [7:0]              w_byte,
    output logic [WORD_BYTES*8-1:0] r_word,
    output logic                    r_word_vld
);
    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0]           idx;
    logic [WORD_BYTES*8-9:0]    acc;
    logic                       last;

    assign last = w_vld && (idx == IDX_W'(WORD_BYTES - 1));

    // r_word only moves on word completion, so it holds between write strobes
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            idx        <= '0;
            acc        <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= last && !w_clr;
            if (w_clr) begin
                idx <= '0;
            end else if (w_vld) begin
                idx <= idx + 1'b1;
                acc <= {acc[WORD_BYTES*8-17:0], w_byte};
                if (last) r_word <= {acc, w_byte};
            end
        end
    end
endmodule

// File: rtl/m_prog_loader.sv
// Loads a length-prefixed byte stream into word memory while holding the CPU in reset.
// Define LOADER_CKSUM_EN to require a trailing modulo-256 checksum byte after the data.
module m_prog_loader import m_prog_loader_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic            w_start,
    m_prog_loader_if.slave  bus,
    output logic            r_cpu_rst,
    output logic            r_busy,
    output logic            r_done,
    output logic            r_err
);
    localparam int                HDR_BITS  = HDR_BYTES * 8;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;
`ifdef LOADER_CKSUM_EN
    localparam ld_state_e DATA_NEXT = CKSUM;
`else
    localparam ld_state_e DATA_NEXT = IDLE;
`endif

    ld_state_e           st, nxt;
    logic [7:0]          hdr_hi;
    logic [HDR_BITS-1:0] hdr_n, n_words;
    logic [HDR_BITS+1:0] dcnt;
    logic [ADDR_W-1:0]   ptr, addr_q;
    logic [31:0]         pk_word;
    logic                rdy, acc, start_acc, data_acc, last_byte, hdr_bad, go_done, pk_vld;

    assign hdr_n     = {hdr_hi, bus.w_rx_data};
    assign hdr_bad   = (hdr_n == '0) || (32'(hdr_n) > MAX_WORDS);
    assign acc       = rdy && bus.w_rx_valid;
    assign start_acc = w_start && (st == IDLE || st == ERR);
    assign data_acc  = acc && (st == DATA);
    // byte index 4N-1 closes the last word
    assign last_byte = (dcnt == {n_words - 1'b1, 2'b11});

`ifdef LOADER_CKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)       csum <= '0;
        else if (start_acc) csum <= '0;
        else if (data_acc)  csum <= csum + bus.w_rx_data;
    end
    assign go_done = (st == CKSUM) && acc && (bus.w_rx_data == csum);
`else
    // done follows the final write strobe by one cycle
    logic last_pend;
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) last_pend <= 1'b0;
        else          last_pend <= data_acc && last_byte;
    end
    assign go_done = last_pend;
`endif

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) st <= IDLE;
        else          st <= nxt;
    end

    always_comb begin
        nxt = st;
        rdy = 1'b0;
        case (st)
            IDLE, ERR: if (w_start) nxt = HDR_HI;
            HDR_HI: begin
                rdy = 1'b1;
                if (bus.w_rx_valid) nxt = HDR_LO;
            end
            HDR_LO: begin
                rdy = 1'b1;
                if (bus.w_rx_valid) nxt = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                rdy = 1'b1;
                if (bus.w_rx_valid && last_byte) nxt = DATA_NEXT;
            end
`ifdef LOADER_CKSUM_EN
            CKSUM: begin
                rdy = 1'b1;
                if (bus.w_rx_valid) nxt = (bus.w_rx_data == csum) ? IDLE : ERR;
            end
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            hdr_hi  <= '0;
            n_words <= '0;
            dcnt    <= '0;
            ptr     <= BASE;
            addr_q  <= BASE;
        end else begin
            if (start_acc) begin
                dcnt <= '0;
                ptr  <= BASE;
            end else if (data_acc) begin
                dcnt <= dcnt + 1'b1;
                if (dcnt[1:0] == 2'b11) begin
                    addr_q <= ptr;
                    ptr    <= ptr + 1'b1;
                end
            end
            if (acc && st == HDR_HI) hdr_hi  <= bus.w_rx_data;
            if (acc && st == HDR_LO) n_words <= hdr_n;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b0;
        end else if (start_acc) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else if (nxt == ERR && st != ERR) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
        end else if (go_done) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cpu_rst <= 1'b0;
        end
    end

    m_byte_packer u_pack (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_clr      (start_acc),
        .w_vld      (data_acc),
        .w_byte     (bus.w_rx_data),
        .r_word     (pk_word),
        .r_word_vld (pk_vld)
    );

    assign bus.r_rx_ready = rdy;
    assign bus.r_mem_we   = pk_vld;
    assign bus.r_mem_din  = pk_word;
    assign bus.r_mem_addr = addr_q;
endmodule
